// File: rtl/rf_scoreboard.sv
// Register scoreboard and stall controller: per-register pending-write counters plus one long-latency unit.
// Optional macro RF_SCOREBOARD_FORWARD_EN: per-register late bits, so only load/long results stall readers.
module rf_scoreboard #(
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 2,
  parameter int LONG_LAT  = 33,
  parameter int INF_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [RF_ADDR_W-1:0] issue_src1,
  input  logic                 issue_src1_en,
  input  logic [RF_ADDR_W-1:0] issue_src2,
  input  logic                 issue_src2_en,
  input  logic [RF_ADDR_W-1:0] issue_dest,
  input  logic                 issue_gr_we,
  input  logic                 issue_is_load,
  input  logic                 issue_is_long,
  input  logic                 wb_valid,
  input  logic [RF_ADDR_W-1:0] wb_dest,
  input  logic                 wb_gr_we,
  input  logic                 flush,
  output logic                 busy_src1,
  output logic                 busy_src2,
  output logic                 long_busy,
  output logic                 long_done,
  output logic [INF_W-1:0]     inflight_cnt
);

  localparam int NREG  = 2**RF_ADDR_W;
  localparam int SUM_W = RF_ADDR_W + CNT_W + 1;

  logic [CNT_W-1:0] pend     [NREG];
  logic [CNT_W-1:0] pend_nxt [NREG];
  logic [SUM_W-1:0] sum, sum_nxt;
  logic [7:0]       long_cnt;

  logic issue_fire, trk_issue, trk_retire;
  logic haz1, haz2, dest_sat;

  // Exact in-flight total is kept internally; only the output view saturates.
  function automatic logic [INF_W-1:0] sat_inf(input logic [SUM_W-1:0] v);
    if (v > SUM_W'((2**INF_W) - 1))
      return '1;
    else
      return v[INF_W-1:0];
  endfunction

  assign issue_fire = issue_valid & issue_ready;
  assign trk_issue  = issue_fire & issue_gr_we & (issue_dest != '0);
  assign trk_retire = wb_valid & wb_gr_we & (wb_dest != '0) & (pend[wb_dest] != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_nxt[r] = pend[r];
      if (trk_issue && issue_dest == RF_ADDR_W'(r) && !(trk_retire && wb_dest == RF_ADDR_W'(r)))
        pend_nxt[r] = pend[r] + 1'b1;
      else if (trk_retire && wb_dest == RF_ADDR_W'(r) && !(trk_issue && issue_dest == RF_ADDR_W'(r)))
        pend_nxt[r] = pend[r] - 1'b1;
    end
  end

  assign sum_nxt = sum + SUM_W'(trk_issue) - SUM_W'(trk_retire);

`ifdef RF_SCOREBOARD_FORWARD_EN
  logic [NREG-1:0] late, late_nxt;

  // Only results the datapath cannot forward keep the late bit; a plain ALU rewrite clears it.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      late_nxt[r] = late[r];
      if (pend_nxt[r] == '0)
        late_nxt[r] = 1'b0;
      else if (trk_issue && issue_dest == RF_ADDR_W'(r))
        late_nxt[r] = issue_is_load | issue_is_long;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush)
      late <= '0;
    else
      late <= late_nxt;
  end

  assign haz1 = (pend[issue_src1] != '0) & late[issue_src1];
  assign haz2 = (pend[issue_src2] != '0) & late[issue_src2];
`else
  logic unused_is_load;
  assign unused_is_load = issue_is_load;

  assign haz1 = (pend[issue_src1] != '0);
  assign haz2 = (pend[issue_src2] != '0);
`endif

  assign busy_src1 = issue_src1_en & (issue_src1 != '0) & haz1;
  assign busy_src2 = issue_src2_en & (issue_src2 != '0) & haz2;
  assign dest_sat  = issue_gr_we & (pend[issue_dest] == '1);

  assign issue_ready = !reset & !flush & !busy_src1 & !busy_src2 & !dest_sat
                       & !(issue_is_long & long_busy);

  assign inflight_cnt = sat_inf(sum);

  // State update: flush discards everything in flight, including same-cycle writeback.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      sum       <= '0;
      long_cnt  <= '0;
      long_busy <= 1'b0;
      long_done <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) pend[r] <= pend_nxt[r];
      sum       <= sum_nxt;
      long_done <= 1'b0;
      if (issue_fire && issue_is_long) begin
        long_cnt  <= 8'(LONG_LAT - 1);
        long_busy <= 1'b1;
      end else if (long_busy) begin
        if (long_cnt == '0) begin
          long_busy <= 1'b0;
          long_done <= 1'b1;
        end else begin
          long_cnt <= long_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: per-cycle vector table through an expectation queue, plus long-unit/flush/reset sequences.
module tb_rf_scoreboard;

`ifdef RF_SCOREBOARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, issue_valid, issue_ready;
  logic [4:0] issue_src1, issue_src2, issue_dest, wb_dest;
  logic       issue_src1_en, issue_src2_en, issue_gr_we, issue_is_load, issue_is_long;
  logic       wb_valid, wb_gr_we, flush;
  logic       busy_src1, busy_src2, long_busy, long_done;
  logic [3:0] inflight_cnt;

  int errors = 0;
  int checks = 0;

  rf_scoreboard #(.RF_ADDR_W(5), .CNT_W(2), .LONG_LAT(33), .INF_W(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1(issue_src1), .issue_src1_en(issue_src1_en),
    .issue_src2(issue_src2), .issue_src2_en(issue_src2_en),
    .issue_dest(issue_dest), .issue_gr_we(issue_gr_we),
    .issue_is_load(issue_is_load), .issue_is_long(issue_is_long),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_gr_we(wb_gr_we),
    .flush(flush),
    .busy_src1(busy_src1), .busy_src2(busy_src2),
    .long_busy(long_busy), .long_done(long_done),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, vld;
    logic [4:0] s1;
    logic       s1en;
    logic [4:0] dest;
    logic       we, ld;
    logic       wbv;
    logic [4:0] wbd;
    logic       e_rdy, e_b1;
    logic [3:0] e_inf;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];

  function automatic vec_t v(bit rst, bit vld, int s1, bit s1en, int dest, bit we, bit ld,
                             bit wbv, int wbd, bit rdy, bit b1, int inf);
    vec_t t;
    t.rst = rst; t.vld = vld; t.s1 = 5'(s1); t.s1en = s1en; t.dest = 5'(dest);
    t.we = we; t.ld = ld; t.wbv = wbv; t.wbd = 5'(wbd);
    t.e_rdy = rdy; t.e_b1 = b1; t.e_inf = 4'(inf);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the active edge.
  task automatic drive(bit rst, bit vld, int s1, bit s1en, int dest, bit we, bit ld, bit lg,
                       bit wbv, int wbd, bit fl);
    @(posedge clk);
    #1;
    reset = rst; issue_valid = vld; issue_src1 = 5'(s1); issue_src1_en = s1en;
    issue_src2 = 5'd0; issue_src2_en = 1'b0;
    issue_dest = 5'(dest); issue_gr_we = we; issue_is_load = ld; issue_is_long = lg;
    wb_valid = wbv; wb_dest = 5'(wbd); wb_gr_we = wbv; flush = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t, e;
    reset = 1'b1; issue_valid = 1'b0; issue_src1 = '0; issue_src1_en = 1'b0;
    issue_src2 = '0; issue_src2_en = 1'b0; issue_dest = '0; issue_gr_we = 1'b0;
    issue_is_load = 1'b0; issue_is_long = 1'b0; wb_valid = 1'b0; wb_dest = '0;
    wb_gr_we = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);

    // rst vld s1 en dest we ld wbv wbd | rdy b1 inf
    tbl.push_back(v(1,1,0,0,3,1,0,0,0, 0,0,0));
    tbl.push_back(v(0,1,0,0,3,1,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, FWD,!FWD,1));
    tbl.push_back(v(0,1,3,1,0,0,0,1,3, FWD,!FWD,1));
    tbl.push_back(v(0,1,3,1,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,0,0,5,1,1,0,0, 1,0,0));
    tbl.push_back(v(0,1,5,1,0,0,0,0,0, 0,1,1));
    tbl.push_back(v(0,1,5,1,0,0,0,1,5, 0,1,1));
    tbl.push_back(v(0,1,5,1,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,0,1,0,1,0,0,0, 1,0,0));
    tbl.push_back(v(0,0,0,1,0,0,0,1,0, 1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,1));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,2));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 0,0,3));
    tbl.push_back(v(0,1,0,0,7,1,0,1,7, 0,0,3));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,2));
    tbl.push_back(v(0,0,0,0,7,1,0,1,7, 0,0,3));
    tbl.push_back(v(0,1,0,0,7,1,0,1,7, 1,0,2));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,2));
    tbl.push_back(v(0,0,0,0,7,1,0,0,0, 0,0,3));
    tbl.push_back(v(0,0,0,0,0,0,0,1,7, 1,0,3));
    tbl.push_back(v(0,0,0,0,0,0,0,1,7, 1,0,2));
    tbl.push_back(v(0,0,0,0,0,0,0,1,7, 1,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,1,7, 1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,0,0,7,1,0,0,0, 1,0,0));
    tbl.push_back(v(0,1,7,1,0,0,0,0,0, FWD,!FWD,1));
    tbl.push_back(v(0,1,7,1,0,0,0,1,7, FWD,!FWD,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(t.rst, t.vld, t.s1, t.s1en, t.dest, t.we, t.ld, 1'b0, t.wbv, t.wbd, 1'b0);
      expq.push_back(t);
      @(negedge clk);
      e = expq.pop_front();
      chk($sformatf("row%0d issue_ready", i), issue_ready, e.e_rdy);
      chk($sformatf("row%0d busy_src1", i), busy_src1, e.e_b1);
      chk($sformatf("row%0d inflight_cnt", i), inflight_cnt, e.e_inf);
      chk($sformatf("row%0d long_busy", i), long_busy, 0);
      chk($sformatf("row%0d long_done", i), long_done, 0);
    end

    // Long op at cycle t: busy t+1..t+33, done pulse at t+34, second long accepted at t+34.
    drive(0,1,0,0,0,0,0,1,0,0,0);
    @(negedge clk);
    chk("long_issue ready", issue_ready, 1);
    for (int k = 1; k <= 33; k++) begin
      drive(0,1,0,0,0,0,0,1,0,0,0);
      @(negedge clk);
      chk($sformatf("long t+%0d busy", k), long_busy, 1);
      chk($sformatf("long t+%0d done", k), long_done, 0);
      chk($sformatf("long t+%0d ready", k), issue_ready, 0);
    end
    drive(0,1,0,0,0,0,0,1,0,0,0);
    @(negedge clk);
    chk("long t+34 busy", long_busy, 0);
    chk("long t+34 done", long_done, 1);
    chk("long t+34 ready", issue_ready, 1);

    // Four writes behind the second long op, then flush.
    for (int k = 1; k <= 4; k++) begin
      drive(0,1,0,0,k,1,0,0,0,0,0);
      @(negedge clk);
      chk($sformatf("pre-flush write r%0d ready", k), issue_ready, 1);
      chk($sformatf("pre-flush write r%0d long_busy", k), long_busy, 1);
      chk($sformatf("pre-flush write r%0d done", k), long_done, 0);
    end
    drive(0,1,0,0,9,1,0,0,1,1,1);
    @(negedge clk);
    chk("flush cycle ready", issue_ready, 0);
    chk("flush cycle inflight", inflight_cnt, 4);
    chk("flush cycle long_busy", long_busy, 1);
    drive(0,1,4,1,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("post-flush inflight", inflight_cnt, 0);
    chk("post-flush long_busy", long_busy, 0);
    chk("post-flush busy_src1", busy_src1, 0);
    chk("post-flush ready", issue_ready, 1);
    for (int k = 0; k < 40; k++) begin
      drive(0,0,0,0,0,0,0,0,0,0,0);
      @(negedge clk);
      chk($sformatf("abandoned long done c%0d", k), long_done, 0);
    end

    // Reset mid-operation.
    drive(0,1,0,0,6,1,0,0,0,0,0);
    @(negedge clk);
    chk("pre-reset write ready", issue_ready, 1);
    drive(1,1,0,0,6,1,0,0,0,0,0);
    @(negedge clk);
    chk("reset cycle ready", issue_ready, 0);
    chk("reset cycle inflight", inflight_cnt, 1);
    drive(0,1,6,1,0,0,0,0,0,0,0);
    @(negedge clk);
    chk("post-reset inflight", inflight_cnt, 0);
    chk("post-reset busy_src1", busy_src1, 0);
    chk("post-reset ready", issue_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
